// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: stage phase encoding, default widths and
// the complex sample type used between pipeline stages.
package fft_pkg;

    localparam int FFT_DW    = 24;  // data width per component
    localparam int FFT_TW    = 24;  // twiddle width per component
    localparam int FFT_TWF   = 8;   // twiddle fractional bits (256 = +1.0)
    localparam int FFT_DEPTH = 8;   // feedback delay of this stage

    // Phase reported by the twiddle generator of the same stage.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BF   = 2'd1,
        ST_TW   = 2'd2,
        ST_ILL  = 2'd3
    } phase_t;

    // Complex sample at the default data width.
    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_cmul.sv
// Combinational complex multiply by a fixed-point twiddle.
// Full-width products, one guard bit on the sum, floor shift by TWF, then
// truncation back to DW bits.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int DW  = FFT_DW,
    parameter int TW  = FFT_TW,
    parameter int TWF = FFT_TWF
) (
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [TW-1:0] b_r,
    input  logic signed [TW-1:0] b_i,
    output logic signed [DW-1:0] y_r,
    output logic signed [DW-1:0] y_i
);

    logic signed [DW+TW-1:0] p_rr;
    logic signed [DW+TW-1:0] p_ii;
    logic signed [DW+TW-1:0] p_ri;
    logic signed [DW+TW-1:0] p_ir;
    logic signed [DW+TW:0]   s_re;
    logic signed [DW+TW:0]   s_im;

    assign p_rr = a_r * b_r;
    assign p_ii = a_i * b_i;
    assign p_ri = a_r * b_i;
    assign p_ir = a_i * b_r;

    assign s_re = p_rr - p_ii;
    assign s_im = p_ri + p_ir;

    // Arithmetic shift floors toward minus infinity; the upper bits are
    // dropped, so out-of-range results wrap.
    assign y_r = DW'(s_re >>> TWF);
    assign y_i = DW'(s_im >>> TWF);

endmodule

// File: rtl/sdf_bf_stage_8.sv
// Radix-2 DIF single-path delay-feedback butterfly stage, 8-entry feedback.
// Phase and twiddle come from the stage's twiddle generator; this block
// fills the delay line, forms sum/difference, and applies the twiddle to
// the samples coming back out of the delay line.
module sdf_bf_stage_8
    import fft_pkg::*;
#(
    parameter int DW    = FFT_DW,
    parameter int TW    = FFT_TW,
    parameter int TWF   = FFT_TWF,
    parameter int DEPTH = FFT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    input  logic [1:0]           state,
    input  logic signed [TW-1:0] w_r,
    input  logic signed [TW-1:0] w_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i
);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } samp_t;

    phase_t               phase;
    samp_t                line [DEPTH];   // line[DEPTH-1] is the oldest entry
    logic signed [DW-1:0] head_r;
    logic signed [DW-1:0] head_i;
    logic signed [DW-1:0] sum_r;
    logic signed [DW-1:0] sum_i;
    logic signed [DW-1:0] diff_r;
    logic signed [DW-1:0] diff_i;
    logic signed [DW-1:0] tw_r;
    logic signed [DW-1:0] tw_i;

    logic                 shift_en;
    samp_t                push;
    logic                 valid_nxt;
    logic signed [DW-1:0] dout_r_nxt;
    logic signed [DW-1:0] dout_i_nxt;

    assign phase  = phase_t'(state);
    assign head_r = line[DEPTH-1].re;
    assign head_i = line[DEPTH-1].im;

    // Butterfly arithmetic wraps at DW bits; upstream leaves one bit of
    // headroom so no scaling is applied here.
    assign sum_r  = head_r + din_r;
    assign sum_i  = head_i + din_i;
    assign diff_r = head_r - din_r;
    assign diff_i = head_i - din_i;

    fft_cmul #(
        .DW  (DW),
        .TW  (TW),
        .TWF (TWF)
    ) u_cmul (
        .a_r (head_r),
        .a_i (head_i),
        .b_r (w_r),
        .b_i (w_i),
        .y_r (tw_r),
        .y_i (tw_i)
    );

    // Select what enters the delay line and what goes out, by phase.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        shift_en   = 1'b0;
        push.re    = din_r;
        push.im    = din_i;
        valid_nxt  = 1'b0;
        dout_r_nxt = dout_r;
        dout_i_nxt = dout_i;
        case (phase)
            ST_FILL: begin
                shift_en = in_valid;
            end
            ST_BF: begin
                shift_en   = 1'b1;
                push.re    = diff_r;
                push.im    = diff_i;
                valid_nxt  = 1'b1;
                dout_r_nxt = sum_r;
                dout_i_nxt = sum_i;
            end
            ST_TW: begin
                shift_en   = 1'b1;
                valid_nxt  = 1'b1;
                dout_r_nxt = tw_r;
                dout_i_nxt = tw_i;
            end
            default: begin
                // Illegal phase: behave like fill but keep the line intact.
            end
        endcase
    end

    // Register outputs and advance the delay line.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage of the shift reads
        // the pre-edge value of its neighbour.
        if (rst) begin
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
            // NOTE: the delay line is cleared on reset so an aborted frame
            // leaves no residue in the next frame's butterflies.
            for (int i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            out_valid <= valid_nxt;
            dout_r    <= dout_r_nxt;
            dout_i    <= dout_i_nxt;
            if (shift_en) begin
                line[0] <= push;
                for (int i = 1; i < DEPTH; i++) begin
                    line[i] <= line[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdf_bf_stage_8.sv
// Self-checking bench for sdf_bf_stage_8: a FIFO-based behavioural model
// checked every cycle, plus hand-computed expectations for known cases.
module tb_sdf_bf_stage_8;
    import fft_pkg::*;

    localparam int    DW    = 24;
    localparam int    TW    = 24;
    localparam int    TWF   = 8;
    localparam int    DEPTH = 8;
    localparam longint MAXP = 64'sd8388607;   // 2^23 - 1

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic [1:0]           state;
    logic signed [TW-1:0] w_r;
    logic signed [TW-1:0] w_i;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // Reference model state: FIFO of stored samples, front = oldest.
    longint q_r[$];
    longint q_i[$];
    longint exp_r;
    longint exp_i;
    logic   exp_v;

    always #5 clk = ~clk;

    sdf_bf_stage_8 #(
        .DW    (DW),
        .TW    (TW),
        .TWF   (TWF),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .state     (state),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reduce to a DW-bit two's complement value.
    function automatic longint wrap(input longint x);
        longint m;
        m = x % (64'sd1 << DW);
        if (m < 0) m = m + (64'sd1 << DW);
        if (m >= (64'sd1 << (DW - 1))) m = m - (64'sd1 << DW);
        return m;
    endfunction

    // Floor division by 2^TWF.
    function automatic longint fdiv(input longint p);
        longint q;
        q = p / (64'sd1 << TWF);
        if ((p % (64'sd1 << TWF)) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint rnd24();
        logic [31:0]          r;
        logic signed [DW-1:0] v;
        r = $urandom;
        v = r[DW-1:0];
        return longint'(v);
    endfunction

    function automatic void model_push(input longint re, input longint im);
        void'(q_r.pop_front());
        void'(q_i.pop_front());
        q_r.push_back(re);
        q_i.push_back(im);
    endfunction

    // Model update on each edge, then compare the DUT against it.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            q_r.push_back(0);
            q_i.push_back(0);
        end
        exp_r = 0;
        exp_i = 0;
        exp_v = 1'b0;
        forever begin
            @(posedge clk);
            if (done) break;
            begin
                longint hr, hi, xr, xi, cr, ci;
                hr = q_r[0];
                hi = q_i[0];
                xr = longint'(din_r);
                xi = longint'(din_i);
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        q_r[i] = 0;
                        q_i[i] = 0;
                    end
                    exp_r = 0;
                    exp_i = 0;
                    exp_v = 1'b0;
                end else begin
                    case (state)
                        2'd0: begin
                            if (in_valid) model_push(xr, xi);
                            exp_v = 1'b0;
                        end
                        2'd1: begin
                            exp_r = wrap(hr + xr);
                            exp_i = wrap(hi + xi);
                            model_push(wrap(hr - xr), wrap(hi - xi));
                            exp_v = 1'b1;
                        end
                        2'd2: begin
                            cr = longint'(w_r);
                            ci = longint'(w_i);
                            exp_r = wrap(fdiv(hr * cr - hi * ci));
                            exp_i = wrap(fdiv(hr * ci + hi * cr));
                            model_push(xr, xi);
                            exp_v = 1'b1;
                        end
                        default: exp_v = 1'b0;
                    endcase
                end
            end
            #1;
            check("model_valid", {63'd0, out_valid}, {63'd0, exp_v});
            check("model_re", 64'(dout_r), 64'(exp_r));
            check("model_im", 64'(dout_i), 64'(exp_i));
        end
    end

    task automatic drive(input logic r, input logic [1:0] st, input logic v,
                         input longint dr, input longint di,
                         input longint wr, input longint wi);
        @(negedge clk);
        rst      = r;
        state    = st;
        in_valid = v;
        din_r    = dr[DW-1:0];
        din_i    = di[DW-1:0];
        w_r      = wr[TW-1:0];
        w_i      = wi[TW-1:0];
    endtask

    // Check outputs after the edge that consumes the last driven cycle.
    task automatic expect_out(input string name, input logic v,
                              input longint er, input longint ei);
        @(posedge clk);
        #2;
        check({name, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        check({name, "_re"}, 64'(dout_r), 64'(er));
        check({name, "_im"}, 64'(dout_i), 64'(ei));
    endtask

    initial begin
        rst      = 1'b1;
        state    = ST_FILL;
        in_valid = 1'b1;
        din_r    = 24'sd55;
        din_i    = -24'sd9;
        w_r      = 24'sd256;
        w_i      = 24'sd0;

        // Reset held two cycles with live input.
        drive(1'b1, ST_FILL, 1'b1, 55, -9, 256, 0);
        drive(1'b1, ST_BF, 1'b1, 77, 3, 256, 0);
        expect_out("reset", 1'b0, 0, 0);

        // Fill with 1..8, then butterflies with 9..16.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, ST_FILL, 1'b1, k + 1, 0, 256, 0);
        end
        expect_out("fill", 1'b0, 0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, ST_BF, 1'b1, k + 9, 0, 256, 0);
            expect_out("bf_sum", 1'b1, 10 + 2 * k, 0);
        end

        // Twiddles applied to the stored differences (-8, 0).
        for (int k = 0; k < DEPTH; k++) begin
            longint wr, wi;
            wr = 256;
            wi = 0;
            if (k == 2) begin wr = 181; wi = -181; end
            if (k == 4) begin wr = 0;   wi = -256; end
            drive(1'b0, ST_TW, 1'b1, k + 17, 0, wr, wi);
            if (k == 0) expect_out("tw_unity", 1'b1, -8, 0);
            if (k == 2) expect_out("tw_round", 1'b1, -6, 5);
            if (k == 4) expect_out("tw_minus_j", 1'b1, 0, 8);
        end

        // Overflow wrap on the sum; difference comes back through the twiddle.
        drive(1'b1, ST_FILL, 1'b0, 0, 0, 256, 0);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, ST_FILL, 1'b1, MAXP, 0, 256, 0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, ST_BF, 1'b1, 1, 0, 256, 0);
            if (k == 0) expect_out("wrap_sum", 1'b1, -MAXP - 1, 0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, ST_TW, 1'b1, 5, 5, 256, 0);
            if (k == 0) expect_out("wrap_diff", 1'b1, MAXP - 1, 0);
        end

        // Reset in the middle of the twiddle phase.
        drive(1'b1, ST_TW, 1'b1, 5, 5, 256, 0);
        expect_out("mid_reset", 1'b0, 0, 0);
        drive(1'b0, ST_BF, 1'b1, 7, 3, 256, 0);
        expect_out("cleared_line", 1'b1, 7, 3);
        drive(1'b1, ST_FILL, 1'b0, 0, 0, 256, 0);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, ST_FILL, 1'b1, 100 + k, 1, 256, 0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, ST_BF, 1'b1, k, 0, 256, 0);
            expect_out("refill", 1'b1, 100 + 2 * k, 1);
        end

        // Illegal phase holds everything.
        drive(1'b0, ST_ILL, 1'b1, 999, 999, 256, 0);
        expect_out("illegal", 1'b0, 114, 1);

        // Randomized frames, checked by the model process.
        for (int f = 0; f < 6; f++) begin
            int pushes;
            int guard;
            drive(1'b1, ST_FILL, 1'b0, 0, 0, 256, 0);
            pushes = 0;
            guard  = 0;
            while (pushes < DEPTH && guard < 200) begin
                int r;
                r = int'($urandom_range(0, 5));
                guard++;
                if (r == 0) begin
                    drive(1'b0, ST_ILL, 1'($urandom_range(0, 1)), rnd24(), rnd24(), rnd24(), rnd24());
                end else if (r == 1) begin
                    drive(1'b0, ST_FILL, 1'b0, rnd24(), rnd24(), rnd24(), rnd24());
                end else begin
                    drive(1'b0, ST_FILL, 1'b1, rnd24(), rnd24(), rnd24(), rnd24());
                    pushes++;
                end
            end
            for (int b = 0; b < 3; b++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    drive(1'b0, ST_BF, 1'($urandom_range(0, 1)), rnd24(), rnd24(), rnd24(), rnd24());
                end
                for (int k = 0; k < DEPTH; k++) begin
                    longint wr, wi;
                    if (f[0]) begin
                        wr = rnd24();
                        wi = rnd24();
                    end else begin
                        wr = longint'($urandom_range(0, 512)) - 256;
                        wi = longint'($urandom_range(0, 512)) - 256;
                    end
                    drive(1'b0, ST_TW, 1'($urandom_range(0, 1)), rnd24(), rnd24(), wr, wi);
                end
            end
        end

        drive(1'b0, ST_FILL, 1'b0, 0, 0, 256, 0);
        @(posedge clk);
        #3;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
